// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a small 8-bit register bank, oversampled in the system clock domain.
// Command byte: bit7 = write, low AW bits = start address; later bytes stream data with address auto-increment.
// Register 0 is a read-only ID. Optional macro SPI_TARGET_ECHO_EN echoes received bytes on poci during writes.
module spi_target_regs #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] ID_VALUE = 8'hA5,
    localparam int        AW       = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic                  cs,
    output logic                  poci,
    output logic                  wr_valid,
    output logic [AW-1:0]         wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic [NUM_REGS*8-1:0] regs_flat
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state;
    state_t        state_next;
    logic          sclk_s1, sclk_s2, sclk_s3;
    logic          cs_s1, cs_s2, cs_s3;
    logic          pico_s1, pico_s2;
    logic          sclk_rise, sclk_fall, cs_fall;
    logic          active, byte_done;
    logic [2:0]    bitcnt;
    logic [7:0]    rx_shift, tx_shift, rx_byte;
    logic          rw;
    logic [AW-1:0] addr;
    logic [7:0]    regs [NUM_REGS];

    // Bring the SPI pins into the clock domain; the third sclk/cs stage is kept for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
            cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_s3   <= 1'b1;
            pico_s1 <= 1'b0; pico_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
            cs_s1   <= cs;      cs_s2   <= cs_s1;   cs_s3   <= cs_s2;
            pico_s1 <= pico;    pico_s2 <= pico_s1;
        end
    end

    // State register for the transfer sequencer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Edge detection, byte completion and next-state selection.
    always_comb begin
        sclk_rise  = sclk_s2 & ~sclk_s3;
        sclk_fall  = ~sclk_s2 & sclk_s3;
        cs_fall    = ~cs_s2 & cs_s3;
        active     = (state != IDLE);
        rx_byte    = {rx_shift[6:0], pico_s2};
        byte_done  = active && sclk_rise && (bitcnt == 3'd7);
        state_next = state;
        case (state)
            IDLE: if (cs_fall) state_next = CMD;
            CMD: begin
                if (cs_s2)          state_next = IDLE;
                else if (byte_done) state_next = DATA;
            end
            DATA: if (cs_s2) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, register bank updates, write strobe and poci driver.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            poci     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
            bitcnt   <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            rw       <= 1'b0;
            addr     <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 0) ? ID_VALUE : 8'h00;
        end else begin
            wr_valid <= 1'b0;
            busy     <= ~cs_s2;
            if (!active) begin
                poci <= 1'b0;
                if (cs_fall) begin
                    bitcnt   <= 3'd0;
                    rx_shift <= 8'h00;
                    tx_shift <= 8'h00;
                end
            end else if (sclk_rise) begin
                rx_shift <= rx_byte;
                bitcnt   <= bitcnt + 3'd1;
                if (byte_done) begin
                    if (state == CMD) begin
                        rw   <= rx_byte[7];
                        addr <= rx_byte[AW-1:0];
                        if (!rx_byte[7]) tx_shift <= regs[rx_byte[AW-1:0]];
`ifdef SPI_TARGET_ECHO_EN
                        else             tx_shift <= rx_byte;
`else
                        else             tx_shift <= 8'h00;
`endif
                    end else begin
                        if (rw) begin
                            if (addr != '0) begin
                                regs[addr] <= rx_byte;
                                wr_valid   <= 1'b1;
                                wr_addr    <= addr;
                                wr_data    <= rx_byte;
                            end
`ifdef SPI_TARGET_ECHO_EN
                            tx_shift <= rx_byte;
`else
                            tx_shift <= 8'h00;
`endif
                        end else begin
                            tx_shift <= regs[addr + AW'(1)];
                        end
                        addr <= addr + AW'(1);
                    end
                end
            end else if (sclk_fall && !cs_s2) begin
                poci     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // Flatten the register bank for the board top.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*8 +: 8] = regs[i];
    end

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: acts as a mode-0 SPI controller and checks hand-computed results.
module tb_spi_target_regs;

    logic         clock;
    logic         reset;
    logic         sclk;
    logic         pico;
    logic         cs;
    logic         poci;
    logic         wr_valid;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         busy;
    logic [127:0] regs_flat;

    int           checks = 0;
    int           errors = 0;
    int           pulse_count = 0;
    logic [3:0]   last_addr = 4'h0;
    logic [7:0]   last_data = 8'h00;
    logic [7:0]   rx_bytes [4];
    int           base;

    spi_target_regs #(.NUM_REGS(16), .ID_VALUE(8'hA5)) dut (
        .clock    (clock),
        .reset    (reset),
        .sclk     (sclk),
        .pico     (pico),
        .cs       (cs),
        .poci     (poci),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .regs_flat(regs_flat)
    );

    // 50 MHz system clock.
    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Record every write strobe away from the active edge.
    always @(negedge clock) begin
        if (wr_valid) begin
            pulse_count = pulse_count + 1;
            last_addr   = wr_addr;
            last_data   = wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Shift nbits of tx MSB first; poci is sampled just before each rising sclk edge.
    task automatic spiBits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            pico = tx[i];
            repeat (8) @(negedge clock);
            rx[i] = poci;
            sclk = 1'b1;
            repeat (8) @(negedge clock);
            sclk = 1'b0;
        end
    endtask

    // Full transfer of n bytes framed by cs; received bytes land in rx_bytes.
    task automatic applyStimulus(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] tx [4];
        logic [7:0] rx;
        tx[0] = b0; tx[1] = b1; tx[2] = b2; tx[3] = b3;
        @(negedge clock);
        cs = 1'b0;
        repeat (6) @(negedge clock);
        for (int k = 0; k < n; k++) begin
            spiBits(tx[k], 8, rx);
            rx_bytes[k] = rx;
        end
        repeat (8) @(negedge clock);
        cs = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        logic [7:0] dummy;
        reset = 1'b0; sclk = 1'b0; cs = 1'b1; pico = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_poci", poci, 0);
        checkOutput("rst_wr_valid", wr_valid, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_reg0", regs_flat[7:0], 8'hA5);
        checkOutput("rst_reg1", regs_flat[15:8], 8'h00);
        checkOutput("rst_reg15", regs_flat[127:120], 8'h00);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Busy follows cs through the synchronizer.
        cs = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("busy_low_cs", busy, 1);
        cs = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("busy_high_cs", busy, 0);

        // ID read.
        applyStimulus(2, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("id_cmd_byte", rx_bytes[0], 8'h00);
        checkOutput("id_value", rx_bytes[1], 8'hA5);
        checkOutput("id_no_pulse", pulse_count, 0);

        // Single write then readback.
        applyStimulus(2, 8'h81, 8'h3C, 8'h00, 8'h00);
        checkOutput("wr1_pulses", pulse_count, 1);
        checkOutput("wr1_addr", last_addr, 4'h1);
        checkOutput("wr1_data", last_data, 8'h3C);
        checkOutput("wr1_reg1", regs_flat[15:8], 8'h3C);
        applyStimulus(2, 8'h01, 8'h00, 8'h00, 8'h00);
        checkOutput("rd1_data", rx_bytes[1], 8'h3C);

        // Burst write wrapping through the read-only register 0.
        base = pulse_count;
        applyStimulus(4, 8'h8F, 8'h11, 8'h22, 8'h33);
        checkOutput("burst_pulses", pulse_count - base, 2);
        checkOutput("burst_last_addr", last_addr, 4'h1);
        checkOutput("burst_last_data", last_data, 8'h33);
        checkOutput("burst_reg15", regs_flat[127:120], 8'h11);
        checkOutput("burst_reg0", regs_flat[7:0], 8'hA5);
        checkOutput("burst_reg1", regs_flat[15:8], 8'h33);
        applyStimulus(4, 8'h0F, 8'h00, 8'h00, 8'h00);
        checkOutput("rdburst_b1", rx_bytes[1], 8'h11);
        checkOutput("rdburst_b2", rx_bytes[2], 8'hA5);
        checkOutput("rdburst_b3", rx_bytes[3], 8'h33);

        // Abort mid-byte: partial data byte must not commit.
        base = pulse_count;
        @(negedge clock);
        cs = 1'b0;
        repeat (6) @(negedge clock);
        spiBits(8'h82, 8, dummy);
        spiBits(8'hFF, 5, dummy);
        repeat (8) @(negedge clock);
        cs = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("abort_pulses", pulse_count - base, 0);
        checkOutput("abort_reg2", regs_flat[23:16], 8'h00);
        applyStimulus(2, 8'h82, 8'h44, 8'h00, 8'h00);
        checkOutput("after_abort_pulses", pulse_count - base, 1);
        checkOutput("after_abort_reg2", regs_flat[23:16], 8'h44);

        // Reset in the middle of a data byte.
        @(negedge clock);
        cs = 1'b0;
        repeat (6) @(negedge clock);
        spiBits(8'h83, 8, dummy);
        spiBits(8'h55, 4, dummy);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("midrst_reg3", regs_flat[31:24], 8'h00);
        checkOutput("midrst_poci", poci, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_reg2", regs_flat[23:16], 8'h00);
        sclk = 1'b0; cs = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        applyStimulus(2, 8'h00, 8'h00, 8'h00, 8'h00);
        checkOutput("postrst_id", rx_bytes[1], 8'hA5);
        checkOutput("postrst_reg3", regs_flat[31:24], 8'h00);

        // Write transfer: echo build returns previous bytes, default build returns zeros.
        applyStimulus(3, 8'h84, 8'hAA, 8'hBB, 8'h00);
        checkOutput("echo_cmd_phase", rx_bytes[0], 8'h00);
`ifdef SPI_TARGET_ECHO_EN
        checkOutput("echo_b1", rx_bytes[1], 8'h84);
        checkOutput("echo_b2", rx_bytes[2], 8'hAA);
`else
        checkOutput("echo_b1", rx_bytes[1], 8'h00);
        checkOutput("echo_b2", rx_bytes[2], 8'h00);
`endif
        checkOutput("echo_reg4", regs_flat[39:32], 8'hAA);
        checkOutput("echo_reg5", regs_flat[47:40], 8'hBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
